uart_tx_sched: RTL and testbench

- Message-level round-robin scheduler that shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
- Each requester presents bytes on a valid/ready interface, with req_last marking the final byte of a message.
- The scheduler grants one requester at a time and feeds that requester's bytes into uart_tx via tx_start/tx_data, pacing on tx_busy.
- A grant is released on last byte, on the MAX_BYTES fairness cap, or on a stall timeout. Sits between the protocol/framing logic and uart_tx.

---
 rtl/uart_sched_pkg.sv | 27 ++
 rtl/uart_rr_pick.sv | 38 +++
 rtl/uart_tx_sched.sv | 157 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_sched_pkg                                                   |
// | Brief    : Shared types and helpers for the uart_tx byte-stream scheduler.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package uart_sched_pkg;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_FETCH = 2'd1,
        S_ACK   = 2'd2,
        S_WAIT  = 2'd3
    } sched_state_e;

    typedef logic [7:0] byte_t;

    localparam int c_STALL_W = 16;

    // Requester index width; never zero so single-requester builds still elaborate.
    function automatic int req_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_rr_pick                                                     |
// | Brief    : Rotating-priority picker; searches upward from ptr+1 with wrap.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module uart_rr_pick
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = req_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_found,
    output logic [ID_W-1:0]    o_index,
    output logic [NUM_REQ-1:0] o_onehot
);

    always_comb begin
        int w_j;
        w_j      = 0;
        o_found  = 1'b0;
        o_index  = '0;
        o_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_found && i_req[w_j]) begin
                o_found       = 1'b1;
                o_index       = ID_W'(w_j);
                o_onehot[w_j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_tx_sched                                                    |
// | Brief    : Message-level round-robin scheduler feeding one uart_tx.         |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BYTES      = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       sched_busy,
    output logic                       timeout_pulse,
    output logic [$clog2(NUM_REQ)-1:0] timeout_id
);

    localparam int                c_ID_W    = req_id_w(NUM_REQ);
    localparam int                c_BC_W    = (MAX_BYTES > 0) ? $clog2(MAX_BYTES + 1) : 1;
    localparam logic [c_STALL_W-1:0] c_TO_LAST = c_STALL_W'(TIMEOUT_CYCLES - 1);

    sched_state_e         r_state;
    sched_state_e         w_state_next;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_ID_W-1:0]    r_ptr;
    logic [c_BC_W-1:0]    r_byte_cnt;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_last_flag;
    byte_t                r_tx_data;
    logic                 r_tx_start;
    logic                 r_timeout_pulse;
    logic [c_ID_W-1:0]    r_timeout_id;

    logic                 w_found;
    logic [c_ID_W-1:0]    w_pick_idx;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    logic                 w_valid_g;
    logic                 w_last_g;
    byte_t                w_data_g;
    logic                 w_xfer;
    logic                 w_expired;
    logic                 w_cap_hit;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_found  (w_found),
        .o_index  (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    // While a grant is held, r_ptr is the owner's index.
    assign w_valid_g = req_valid[r_ptr];
    assign w_last_g  = req_last[r_ptr];
    assign w_data_g  = req_data[8*int'(r_ptr) +: 8];
    assign w_xfer    = (r_state == S_FETCH) && w_valid_g && !tx_busy;
    assign w_expired = (r_state == S_FETCH) && !w_xfer && (r_stall_cnt == c_TO_LAST);
    assign w_cap_hit = (MAX_BYTES != 0) && ((int'(r_byte_cnt) + 1) == MAX_BYTES);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ARB:   if (w_found) w_state_next = S_FETCH;
            S_FETCH: begin
                if (w_xfer)         w_state_next = S_ACK;
                else if (w_expired) w_state_next = S_ARB;
            end
            S_ACK:   w_state_next = S_WAIT;
            S_WAIT:  if (!tx_busy) w_state_next = r_last_flag ? S_ARB : S_FETCH;
            default: w_state_next = S_ARB;
        endcase
    end

    always_comb begin
        req_ready     = ((r_state == S_FETCH) && !tx_busy) ? r_grant : '0;
        grant         = r_grant;
        sched_busy    = |r_grant;
        tx_data       = r_tx_data;
        tx_start      = r_tx_start;
        timeout_pulse = r_timeout_pulse;
        timeout_id    = r_timeout_id;
    end

    // Pulses default low so tx_start/timeout_pulse can never stretch past one cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_grant         <= '0;
            r_ptr           <= c_ID_W'(NUM_REQ - 1);
            r_byte_cnt      <= '0;
            r_stall_cnt     <= '0;
            r_last_flag     <= 1'b0;
            r_tx_data       <= '0;
            r_tx_start      <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_timeout_id    <= '0;
        end else begin
            r_tx_start      <= 1'b0;
            r_timeout_pulse <= 1'b0;
            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_grant     <= w_pick_onehot;
                        r_ptr       <= w_pick_idx;
                        r_byte_cnt  <= '0;
                        r_stall_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_xfer) begin
                        r_tx_data   <= w_data_g;
                        r_tx_start  <= 1'b1;
                        r_byte_cnt  <= r_byte_cnt + 1'b1;
                        r_last_flag <= w_last_g | w_cap_hit;
                    end else if (w_expired) begin
                        r_grant         <= '0;
                        r_timeout_pulse <= 1'b1;
                        r_timeout_id    <= r_ptr;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        r_stall_cnt <= '0;
                        if (r_last_flag) r_grant <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_sched                                                 |
// | Brief    : Directed bench for uart_tx_sched with a uart_tx busy model.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_sched;

    localparam int N        = 4;
    localparam int MAXB     = 4;
    localparam int TOC      = 20;
    localparam int BUSY_LEN = 6;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [N-1:0]   grant;
    logic           sched_busy;
    logic           timeout_pulse;
    logic [1:0]     timeout_id;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    int   busy_cnt   = 0;
    assign tx_busy = model_busy | hold_busy;

    logic [8:0]   src_mem [N][64];
    int           src_head [N] = '{default: 0};
    int           src_tail [N] = '{default: 0};
    logic [N-1:0] src_flush = '0;

    logic [7:0]   log_data  [64];
    logic [N-1:0] log_grant [64];
    int   log_n      = 0;
    int   dbl_start  = 0;
    int   to_cnt     = 0;
    int   arb_cycles = 0;
    logic prev_start = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_sched #(
        .NUM_REQ        (N),
        .MAX_BYTES      (MAXB),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .grant         (grant),
        .sched_busy    (sched_busy),
        .timeout_pulse (timeout_pulse),
        .timeout_id    (timeout_id)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
    always @(posedge clk) begin
        if (tx_start) begin
            model_busy <= 1'b1;
            busy_cnt   <= BUSY_LEN;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt   <= 0;
            model_busy <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = src_head[i] < src_tail[i];
            req_data[8*i +: 8]  = src_mem[i][src_head[i] & 63][7:0];
            req_last[i]         = src_mem[i][src_head[i] & 63][8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (src_flush[i])                     src_head[i] <= src_tail[i];
            else if (req_valid[i] && req_ready[i]) src_head[i] <= src_head[i] + 1;
        end
    end

    always @(posedge clk) begin
        prev_start <= tx_start;
        if (tx_start && prev_start) dbl_start <= dbl_start + 1;
        if (tx_start) begin
            log_data[log_n & 63]  <= tx_data;
            log_grant[log_n & 63] <= grant;
            log_n                 <= log_n + 1;
        end
        if (timeout_pulse) to_cnt <= to_cnt + 1;
        if (nrst && grant == '0 && |req_valid) arb_cycles <= arb_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [3:0] g, input logic [7:0] d);
        check(tag, 32'({log_grant[idx], log_data[idx]}), 32'({g, d}));
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_tail[r] & 63] = {l, d};
        src_tail[r] = src_tail[r] + 1;
    endtask

    task automatic wait_idle(input int want_n, input string tag);
        int k;
        k = 0;
        while (!(log_n >= want_n && !sched_busy && !tx_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < 2000), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int arb0;
        logic ready_seen;

        repeat (3) @(negedge clk);
        check("rst_grant",     32'(grant),         32'h0);
        check("rst_ready",     32'(req_ready),     32'h0);
        check("rst_tx_start",  32'(tx_start),      32'h0);
        check("rst_tx_data",   32'(tx_data),       32'h0);
        check("rst_sched",     32'(sched_busy),    32'h0);
        check("rst_to_pulse",  32'(timeout_pulse), 32'h0);
        check("rst_to_id",     32'(timeout_id),    32'h0);
        nrst = 1'b1;
        @(negedge clk);

        // Single requester, three-byte message.
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        @(negedge clk);
        check("t1_grant", 32'(grant),     32'h1);
        check("t1_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("t1_start", 32'(tx_start),  32'h1);
        check("t1_data",  32'(tx_data),   32'h41);
        check("t1_ack_ready", 32'(req_ready), 32'h0);
        wait_idle(3, "t1_idle");
        check_log("t1_b0", 0, 4'b0001, 8'h41);
        check_log("t1_b1", 1, 4'b0001, 8'h42);
        check_log("t1_b2", 2, 4'b0001, 8'h43);
        check("t1_grant_rel", 32'(grant), 32'h0);

        // Requesters 1 and 3 simultaneously; ptr=0 so 1 wins, then 3.
        arb0 = arb_cycles;
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b1);
        push(3, 8'hB1, 1'b0);
        push(3, 8'hB2, 1'b1);
        wait_idle(7, "t2_idle");
        check_log("t2_b0", 3, 4'b0010, 8'hA1);
        check_log("t2_b1", 4, 4'b0010, 8'hA2);
        check_log("t2_b2", 5, 4'b1000, 8'hB1);
        check_log("t2_b3", 6, 4'b1000, 8'hB2);
        check("t2_arb_cycles", 32'(arb_cycles - arb0), 32'd2);

        // Fairness cap of 4 bytes: req2 yields to req0 mid-stream.
        for (int i = 0; i < 6; i++) push(2, 8'hC0 + 8'(i), i == 5);
        @(negedge clk);
        check("t3_grant", 32'(grant), 32'h4);
        push(0, 8'hD0, 1'b1);
        wait_idle(14, "t3_idle");
        check_log("t3_b0", 7,  4'b0100, 8'hC0);
        check_log("t3_b3", 10, 4'b0100, 8'hC3);
        check_log("t3_b4", 11, 4'b0001, 8'hD0);
        check_log("t3_b5", 12, 4'b0100, 8'hC4);
        check_log("t3_b6", 13, 4'b0100, 8'hC5);

        // Stall timeout on requester 1; requester 0 served afterwards.
        push(1, 8'h55, 1'b0);
        @(negedge clk);
        check("t4_grant", 32'(grant), 32'h2);
        push(0, 8'h66, 1'b1);
        k = 0;
        while (!timeout_pulse && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_pulse_seen", 32'(timeout_pulse), 32'h1);
        check("t4_to_grant",   32'(grant),         32'h0);
        check("t4_to_id",      32'(timeout_id),    32'h1);
        wait_idle(16, "t4_idle");
        check_log("t4_b0", 14, 4'b0010, 8'h55);
        check_log("t4_b1", 15, 4'b0001, 8'h66);
        check("t4_to_cnt", 32'(to_cnt), 32'd1);

        // Reset while waiting on the first frame of a 4-byte message.
        for (int i = 0; i < 4; i++) push(3, 8'hE0 + 8'(i), i == 3);
        k = 0;
        while (log_n < 17 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_in_wait", 32'(tx_busy && sched_busy), 32'h1);
        nrst = 1'b0;
        src_flush[3] = 1'b1;
        @(negedge clk);
        check("t5_rst_grant", 32'(grant),      32'h0);
        check("t5_rst_start", 32'(tx_start),   32'h0);
        check("t5_rst_data",  32'(tx_data),    32'h0);
        check("t5_rst_sched", 32'(sched_busy), 32'h0);
        check("t5_rst_to_id", 32'(timeout_id), 32'h0);
        nrst = 1'b1;
        src_flush[3] = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_no_start", 32'(log_n), 32'd17);
        push(3, 8'hF0, 1'b0);
        push(3, 8'hF1, 1'b1);
        wait_idle(19, "t5_idle");
        check_log("t5_e0", 16, 4'b1000, 8'hE0);
        check_log("t5_f0", 17, 4'b1000, 8'hF0);
        check_log("t5_f1", 18, 4'b1000, 8'hF1);

        // tx_busy held high for 50 cycles: no transfers, timeouts after 20 stalls.
        hold_busy = 1'b1;
        push(2, 8'h77, 1'b1);
        @(negedge clk);
        check("t6_grant", 32'(grant),     32'h4);
        check("t6_ready", 32'(req_ready), 32'h0);
        ready_seen = 1'b0;
        k = 0;
        while (!timeout_pulse && k < 60) begin
            @(negedge clk);
            k++;
            ready_seen = ready_seen | (|req_ready);
        end
        check("t6_to_latency", 32'(k), 32'd20);
        repeat (50 - k) begin
            @(negedge clk);
            ready_seen = ready_seen | (|req_ready);
        end
        check("t6_ready_low", 32'(ready_seen), 32'h0);
        check("t6_no_start",  32'(log_n),      32'd19);
        check("t6_to_id",     32'(timeout_id), 32'h2);
        check("t6_to_cnt",    32'(to_cnt),     32'd3);
        hold_busy = 1'b0;
        wait_idle(20, "t6_idle");
        check_log("t6_b0", 19, 4'b0100, 8'h77);
        check("dbl_start", 32'(dbl_start), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
